// File: rtl/fp8_mult_arbiter_pkg.sv
// fp8_mult_arbiter_pkg: FP8 format constants and field view shared by the arbiter slice
//   FP8 layout: 1 sign, 3 exponent (bias 3), 4 mantissa with implicit leading one.
package fp8_mult_arbiter_pkg;
    localparam int FP8_W        = 8;
    localparam int FP8_EXP_W    = 3;
    localparam int FP8_MAN_W    = 4;
    localparam int FP8_EXP_BIAS = 3;
    typedef struct packed {
        logic                 sign;
        logic [FP8_EXP_W-1:0] exp;
        logic [FP8_MAN_W-1:0] man;
    } fp8_t;
endpackage

// File: rtl/fp8_mult_arbiter_if.sv
// fp8_mult_arbiter_if: requester-side bus between the PEs and the multiplier arbiter
//   req_valid/req_a/req_b : per-requester operand offers (requester i at [8*i+:8])
//   req_ready             : one-hot grant back to the requesters
//   rsp_valid/id/data     : tagged result strobe, no backpressure
//   master = requester side, slave = arbiter side.
interface fp8_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import fp8_mult_arbiter_pkg::*;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*FP8_W-1:0] req_a;
    logic [NUM_REQ*FP8_W-1:0] req_b;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [FP8_W-1:0]         rsp_data;
    modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_id, rsp_data);
    modport slave  (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/fp8_mult_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
//   req : request vector      ptr : search start index
//   gnt : one-hot grant       idx : encoded grant index    vld : any grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               vld
);
    logic [ID_W:0] s;
    // Walk offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        s   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (ID_W+1)'(k);
            if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
            if (req[s[ID_W-1:0]]) begin
                idx = s[ID_W-1:0];
                vld = 1'b1;
            end
        end
        if (vld) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/fp8_mult_arbiter.sv
// fp8_mult_arbiter: shares one pipelined FP8 multiplier among NUM_REQ requesters
//   clk, rst_n       : clock, async active-low reset
//   bus (slave)      : requester operands/grants and tagged result strobe
//   mul_a, mul_b     : registered operands to the multiplier
//   mul_out          : multiplier result, valid MULT_LAT cycles after mul_a/mul_b
//   busy             : any operation in flight or result being presented
//   grant_cnt        : per-requester saturating handshake counters,
//                      present only when FP8_ARB_STATS_EN is defined
module fp8_mult_arbiter
    import fp8_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MULT_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fp8_mult_arbiter_if.slave  bus,
    output logic [FP8_W-1:0]   mul_a,
    output logic [FP8_W-1:0]   mul_b,
    input  logic [FP8_W-1:0]   mul_out,
    output logic               busy
`ifdef FP8_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gidx;
    logic [NUM_REQ-1:0] gnt;
    logic               gv;
    fp8_t               op_a, op_b;
    // Stage 0 lines up with the operand registers; stages 1..MULT_LAT track the
    // multiplier, so the last stage coincides with mul_out being valid.
    logic [MULT_LAT:0]  tv;
    logic [ID_W-1:0]    tid [MULT_LAT+1];

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .vld (gv)
    );

    assign bus.req_ready = rst_n ? gnt : '0;
    assign mul_a         = op_a;
    assign mul_b         = op_b;
    assign busy          = |tv | bus.rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            tv           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id   <= '0;
            bus.rsp_data <= '0;
            for (int k = 0; k <= MULT_LAT; k++) tid[k] <= '0;
        end else begin
            tv     <= {tv[MULT_LAT-1:0], gv};
            tid[0] <= gidx;
            for (int k = 1; k <= MULT_LAT; k++) tid[k] <= tid[k-1];
            if (gv) begin
                op_a <= bus.req_a[FP8_W*gidx +: FP8_W];
                op_b <= bus.req_b[FP8_W*gidx +: FP8_W];
                ptr  <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            bus.rsp_valid <= tv[MULT_LAT];
            if (tv[MULT_LAT]) begin
                bus.rsp_id   <= tid[MULT_LAT];
                bus.rsp_data <= mul_out;
            end
        end
    end

`ifdef FP8_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                grant_cnt[i*CNT_W +: CNT_W] <= '0;
            else if (gnt[i] && !(&grant_cnt[i*CNT_W +: CNT_W]))
                grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
    end
`endif
endmodule
